// File: rtl/cnn_mem_pkg.sv
// Shared constants and types for the CNN memory path (store_block, load_block, DMA).
// Word/address widths, array depth, DMA direction encoding and the store FSM states.
package cnn_mem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 1024;

  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int LEN_W = IDX_W + 1;

  localparam logic DMA_READ  = 1'b1;
  localparam logic DMA_WRITE = 1'b0;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} store_state_t;

  // Oversized requests are clamped to the array depth without any error flag.
  function automatic logic [LEN_W-1:0] clampLen(input logic [15:0] size);
    if (size > 16'(MAX_WORDS)) return LEN_W'(MAX_WORDS);
    return LEN_W'(size);
  endfunction

endpackage

// File: rtl/store_block.sv
// Streams a block of words from the result array to the DMA write port, one per clock.
// All outputs are registered; the next-cycle values are computed combinationally.
module store_block
  import cnn_mem_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [15:0]                 size,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W*MAX_WORDS-1:0] in,
  output logic                        dmaEnable,
  output logic                        dmaRW,
  output logic [ADDR_W-1:0]           dmaAddr,
  output logic [DATA_W-1:0]           dmaData,
  output logic                        done
);

  store_state_t      state, stateNext;
  logic [IDX_W-1:0]  idx, idxNext;
  logic [LEN_W-1:0]  len, lenNext;
  logic [ADDR_W-1:0] base, baseNext;

  logic              dmaEnableNext, dmaRWNext, doneNext;
  logic [ADDR_W-1:0] dmaAddrNext;
  logic [DATA_W-1:0] dmaDataNext;

  logic [IDX_W-1:0]  fetchIdx;
  logic [DATA_W-1:0] fetchWord;

  // The word registered at the next edge is either the first of a new block or idx+1.
  assign fetchIdx  = (state == IDLE) ? '0 : idx + 1'b1;
  assign fetchWord = in[int'(fetchIdx) * DATA_W +: DATA_W];

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves it unassigned (no latch).
    stateNext     = state;
    idxNext       = idx;
    lenNext       = len;
    baseNext      = base;
    dmaEnableNext = 1'b0;
    dmaRWNext     = DMA_READ;
    dmaAddrNext   = dmaAddr;
    dmaDataNext   = dmaData;
    doneNext      = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          baseNext = address;
          lenNext  = clampLen(size);
          idxNext  = '0;
          if (lenNext != '0) begin
            stateNext     = WRITE;
            dmaEnableNext = 1'b1;
            dmaRWNext     = DMA_WRITE;
            dmaAddrNext   = address;
            dmaDataNext   = fetchWord;
          end else begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end
        end
      end

      WRITE: begin
        if (!enable) begin
          stateNext = IDLE;
        end else if ({1'b0, idx} == len - 1'b1) begin
          stateNext = DONE;
          doneNext  = 1'b1;
        end else begin
          idxNext       = idx + 1'b1;
          dmaEnableNext = 1'b1;
          dmaRWNext     = DMA_WRITE;
          dmaAddrNext   = base + ADDR_W'(idxNext);
          dmaDataNext   = fetchWord;
        end
      end

      DONE: begin
        if (enable) doneNext = 1'b1;
        else        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      len       <= '0;
      base      <= '0;
      dmaEnable <= 1'b0;
      dmaRW     <= DMA_READ;
      dmaAddr   <= '0;
      dmaData   <= '0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state     <= stateNext;
      idx       <= idxNext;
      len       <= lenNext;
      base      <= baseNext;
      dmaEnable <= dmaEnableNext;
      dmaRW     <= dmaRWNext;
      dmaAddr   <= dmaAddrNext;
      dmaData   <= dmaDataNext;
      done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_store_block.sv
// Self-checking bench for store_block: table of block requests plus abort/reset/held-enable sequences.
// Expected DMA writes are queued when a block is started and popped by a negedge monitor.
module tb_store_block;
  import cnn_mem_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        enable;
  logic [15:0]                 size;
  logic [ADDR_W-1:0]           address;
  logic [DATA_W*MAX_WORDS-1:0] inBus;
  logic                        dmaEnable;
  logic                        dmaRW;
  logic [ADDR_W-1:0]           dmaAddr;
  logic [DATA_W-1:0]           dmaData;
  logic                        done;

  store_block dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .size      (size),
    .address   (address),
    .in        (inBus),
    .dmaEnable (dmaEnable),
    .dmaRW     (dmaRW),
    .dmaAddr   (dmaAddr),
    .dmaData   (dmaData),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } write_t;

  typedef struct {
    string       name;
    logic [15:0] size;
    logic [15:0] addr;
    logic [15:0] seed;
    int          expLen;
  } vec_t;

  write_t expQ[$];
  int     assertCount = 0;
  int     failCount   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin : monitor
    write_t w;
    if (!reset) begin
      if (dmaEnable) begin
        check("write expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          w = expQ.pop_front();
          check("write addr", dmaAddr, w.addr);
          check("write data", dmaData, w.data);
          check("write rw", dmaRW, DMA_WRITE);
        end
      end else begin
        check("idle rw", dmaRW, DMA_READ);
      end
    end
  end

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic fillArray(input logic [15:0] seed);
    for (int k = 0; k < MAX_WORDS; k++) inBus[k*DATA_W +: DATA_W] = 16'(seed + 16'(k));
  endtask

  task automatic pushExpected(input logic [15:0] ad, input logic [15:0] seed, input int n);
    write_t w;
    for (int k = 0; k < n; k++) begin
      w.addr = 16'(ad + 16'(k));
      w.data = 16'(seed + 16'(k));
      expQ.push_back(w);
    end
  endtask

  task automatic runBlock(input string name, input logic [15:0] sz, input logic [15:0] ad,
                          input logic [15:0] seed, input int expLen, input bit dropAfter);
    int cycles;
    fillArray(seed);
    pushExpected(ad, seed, expLen);
    size    = sz;
    address = ad;
    enable  = 1'b1;
    waitCycle();
    cycles  = 1;
    size    = ~sz;
    address = ad ^ 16'h5A5A;
    while (!done && cycles < 1100) begin
      waitCycle();
      cycles++;
    end
    check({name, " latency"}, cycles, expLen + 1);
    check({name, " queue drained"}, expQ.size(), 0);
    expQ.delete();
    if (dropAfter) begin
      enable = 1'b0;
      waitCycle();
      check({name, " done cleared"}, done, 1'b0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"basic",   16'd25,   16'd300,   16'd1,     25};
    vecs[1] = '{"zero",    16'd0,    16'd1234,  16'd7,     0};
    vecs[2] = '{"wrap",    16'd4,    16'hFFFE,  16'hAB00,  4};
    vecs[3] = '{"clamp",   16'd2000, 16'h1000,  16'h0040,  1024};
    vecs[4] = '{"single",  16'd1,    16'h0000,  16'h7FFF,  1};
    vecs[5] = '{"full",    16'd1024, 16'd5,     16'h0000,  1024};
    vecs[6] = '{"negdata", 16'd7,    16'h8000,  16'hFFF8,  7};

    reset   = 1'b1;
    enable  = 1'b0;
    size    = '0;
    address = '0;
    inBus   = '0;
    #2;
    check("reset dmaEnable", dmaEnable, 1'b0);
    check("reset dmaRW", dmaRW, DMA_READ);
    check("reset dmaAddr", dmaAddr, 16'h0);
    check("reset dmaData", dmaData, 16'h0);
    check("reset done", done, 1'b0);
    waitCycle();
    waitCycle();
    reset = 1'b0;
    waitCycle();

    for (int i = 0; i < 7; i++)
      runBlock(vecs[i].name, vecs[i].size, vecs[i].addr, vecs[i].seed, vecs[i].expLen, 1'b1);

    // Held enable: done persists and no second block starts until enable drops.
    runBlock("held", 16'd5, 16'd10, 16'h0100, 5, 1'b0);
    repeat (8) waitCycle();
    check("held done stays", done, 1'b1);
    check("held no restart", expQ.size(), 0);
    enable = 1'b0;
    waitCycle();
    check("held done cleared", done, 1'b0);
    runBlock("restart", 16'd3, 16'd50, 16'h0200, 3, 1'b1);

    // Abort: enable dropped right after the 10th write is visible.
    fillArray(16'h0300);
    pushExpected(16'd2000, 16'h0300, 10);
    size    = 16'd100;
    address = 16'd2000;
    enable  = 1'b1;
    repeat (10) waitCycle();
    enable = 1'b0;
    repeat (5) begin
      waitCycle();
      check("abort done low", done, 1'b0);
    end
    check("abort writes", expQ.size(), 0);
    expQ.delete();
    runBlock("abort restart", 16'd3, 16'd2000, 16'h0300, 3, 1'b1);

    // Async reset between edges during the 5th write.
    fillArray(16'h0400);
    pushExpected(16'd700, 16'h0400, 5);
    size    = 16'd20;
    address = 16'd700;
    enable  = 1'b1;
    repeat (5) waitCycle();
    check("pre-reset writing", dmaEnable, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async reset dmaEnable", dmaEnable, 1'b0);
    check("async reset done", done, 1'b0);
    check("async reset dmaRW", dmaRW, DMA_READ);
    check("async reset dmaAddr", dmaAddr, 16'h0);
    check("reset writes", expQ.size(), 0);
    expQ.delete();
    enable = 1'b0;
    waitCycle();
    reset = 1'b0;
    waitCycle();
    check("post reset idle", dmaEnable, 1'b0);
    runBlock("post reset", 16'd2, 16'd900, 16'h0500, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/store_block.md
Name: store_block

Overview:
Writes a contiguous block of 16-bit results from a word array into DMA memory, one word per clock, via the DMA write path (RW=0).
Counterpart of load_block: the convolution layer hands it a base address, a word count and the result array, then waits for done.
Sits between the convolution/pooling layers and the DMA, sharing the DMA address and data pins with load_block through the layer's arbitration.

Parameters:
DATA_W, 16, word width of array entries and DMA data
ADDR_W, 16, DMA address width
MAX_WORDS, 1024, depth of the input array; hard upper bound on size

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and zeroes all outputs
enable  input  1  level request from the layer; a new block starts when seen high in IDLE
size  input  16  number of words to write; sampled at start
address  input  ADDR_W  base DMA address; sampled at start
in  input  DATA_W x MAX_WORDS  signed result array; caller holds it stable from start until done
dmaEnable  output  1  high on every cycle a write is presented to the DMA
dmaRW  output  1  DMA direction: 1=read, 0=write; this block drives 0 while writing, 1 otherwise
dmaAddr  output  ADDR_W  write address
dmaData  output  DATA_W  write data
done  output  1  high from block completion until enable is deasserted

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, dmaEnable=0, dmaRW=1, dmaAddr=0, dmaData=0, done=0.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On a rising edge with enable=1, latch base=address.
  - Latch len=min(size, MAX_WORDS); clamp silently.
  - Set idx=0.
  - Go to WRITE if len>0, else DONE.
- WRITE:
  - Each cycle with idx=k, drive dmaEnable=1, dmaRW=0, dmaAddr=base+k (mod 2^ADDR_W; wraps, no error), dmaData=in[k].
  - First write appears on the outputs the cycle after enable is sampled.
  - One word per cycle; no stall input.
  - After writing idx=len-1, go to DONE: next cycle dmaEnable=0, dmaRW=1, done=1.
  - Latency: start edge to done=1 is len+1 cycles; len=0 gives 1 cycle.
- DONE:
  - Hold done=1; DMA outputs stay idle.
  - When enable=0, go to IDLE and clear done.
  - enable held high never restarts a block; enable must drop for at least one cycle first.
- Abort: enable=0 while in WRITE returns to IDLE next cycle.
  - dmaEnable=0, done stays 0.
  - Words already written are not rolled back.
- Changes to size or address after the start edge are ignored.
- A mid-operation reset aborts immediately with reset values; no further writes occur.
- dmaAddr and dmaData hold their last value when dmaEnable=0.
  - Verification checks them only while dmaEnable=1.

Decomposition:
- Shared package cnn_mem_pkg holds:
  - DATA_W, ADDR_W, MAX_WORDS constants, also used by load_block and DMA
  - DMA_READ=1'b1 and DMA_WRITE=1'b0 direction constants
  - store_state_t enum {IDLE, WRITE, DONE}
- No sub-module: the idx counter, the address adder and the array mux stay inline.
- The array mux is a plain indexed read of in[idx].

Test Plan:
- Basic block: size=25, address=300, in[k]=k+1; pulse reset then enable=1 -> 25 consecutive cycles with dmaEnable=1, dmaRW=0, dmaAddr=300..324, dmaData=1..25; done=1 on cycle 26; DMA memory readback by load_block matches.
- Zero length: size=0, enable=1 -> no dmaEnable pulse; done=1 one cycle after the start edge; enable=0 -> done=0 next cycle.
- Address wrap and clamp: address=16'hFFFE, size=4 -> dmaAddr sequence FFFE, FFFF, 0000, 0001. Separately, size=2000 -> exactly 1024 writes, then done.
- Abort: size=100, enable dropped after the 10th write -> writes stop at addr base+10 at most; done never asserts; a fresh enable restarts at idx 0.
- Async reset mid-block: reset asserted between clock edges during the 5th write -> dmaEnable=0, done=0 immediately without a clock edge; block is IDLE after release.
- Held enable: enable kept at 1 after done -> done stays 1 and no second block starts; dropping and re-raising enable with size=3, address=50 -> writes to 50..52.
